// File: rtl/riscv_multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the simple RISC-V datapath.
// The master side is the sequencer; the slave side is the datapath/memory.
interface riscv_multicycle_ctrl_if;
    logic [31:0] instruction;
    logic        dReady;
    logic        iMemRead;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemtoReg;
    logic        loadPC;
    logic [3:0]  ALUCtrl;
    logic        MemRead;
    logic        MemWrite;
    logic        error;
    logic [31:0] retired;

    modport master (
        input  instruction, dReady,
        output iMemRead, PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC,
               ALUCtrl, MemRead, MemWrite, error, retired
    );

    modport slave (
        output instruction, dReady,
        input  iMemRead, PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC,
               ALUCtrl, MemRead, MemWrite, error, retired
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control sequencer for riscv_simple_datapath: IF/ID/EX/MEM/WB stepping,
// sticky illegal-instruction trap and retired-instruction counter.
//   state | meaning
//   S_IF  | fetch, iMemRead high
//   S_ID  | decode, legality check
//   S_EX  | ALU operation; BEQ completes here
//   S_MEM | data access, waits on dReady; SW completes here
//   S_WB  | register writeback, PC update
//   S_ERR | illegal encoding trapped until reset
module riscv_multicycle_ctrl #(
    parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
    input logic                     clk,
    input logic                     rst,
    riscv_multicycle_ctrl_if.master bus
);
    // INITIAL_PC only mirrors the datapath; reject a misaligned value at elaboration.
    if (INITIAL_PC[1:0] != 2'b00) begin : g_pc_misaligned
        $error("INITIAL_PC must be word aligned");
    end

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SRL = 4'b1000,
                           ALU_SLL = 4'b1001, ALU_SRA = 4'b1010, ALU_XOR = 4'b1101;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_ERR} state_t;

    state_t      state, state_nxt;
    logic [31:0] retired_q;
    logic        retire;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        is_r, is_i, is_lw, is_sw, is_beq, is_shift, f7_zero, f7_alt, legal;
    logic [3:0]  alu_op;

    logic        imr, pcs, als, rw, m2r, lpc, mr, mw, err;
    logic [3:0]  alu;

    assign opcode = bus.instruction[6:0];
    assign funct3 = bus.instruction[14:12];
    assign funct7 = bus.instruction[31:25];

    always_comb begin
        is_r     = (opcode == 7'b0110011);
        is_i     = (opcode == 7'b0010011);
        is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
        is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
        is_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        f7_zero  = (funct7 == 7'b0000000);
        f7_alt   = (funct7 == 7'b0100000);
        case (funct3)
            3'b000:  alu_op = (is_r && bus.instruction[30]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b010:  alu_op = ALU_SLT;
            3'b001:  alu_op = ALU_SLL;
            3'b101:  alu_op = bus.instruction[30] ? ALU_SRA : ALU_SRL;
            default: alu_op = ALU_ADD;
        endcase
        // Immediate forms only constrain funct7 on shifts; register forms always do.
        if (is_r)
            legal = (funct3 != 3'b011) &&
                    (f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
        else if (is_i)
            legal = (funct3 != 3'b011) &&
                    (!is_shift || f7_zero || (f7_alt && funct3 == 3'b101));
        else
            legal = is_lw || is_sw || is_beq;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IF;
            retired_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (retire)
                retired_q <= retired_q + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        imr = 1'b0; pcs = 1'b0; als = 1'b0; rw  = 1'b0; m2r = 1'b0;
        lpc = 1'b0; mr  = 1'b0; mw  = 1'b0; err = 1'b0; alu = ALU_AND;
        case (state)
            S_IF: begin
                imr       = 1'b1;
                state_nxt = S_ID;
            end
            S_ID: state_nxt = legal ? S_EX : S_ERR;
            S_EX: begin
                if (is_lw || is_sw) begin
                    als       = 1'b1;
                    alu       = ALU_ADD;
                    state_nxt = S_MEM;
                end else if (is_beq) begin
                    alu       = ALU_SUB;
                    pcs       = 1'b1;
                    lpc       = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_IF;
                end else begin
                    als       = is_i;
                    alu       = alu_op;
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                als = 1'b1;
                alu = ALU_ADD;
                mr  = is_lw;
                mw  = is_sw;
                if (bus.dReady) begin
                    if (is_sw) begin
                        lpc       = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                rw        = 1'b1;
                lpc       = 1'b1;
                m2r       = is_lw;
                als       = is_lw || is_i;
                alu       = is_lw ? ALU_ADD : alu_op;
                retire    = 1'b1;
                state_nxt = S_IF;
            end
            S_ERR: err = 1'b1;
            default: state_nxt = S_IF;
        endcase
    end

    // Outputs are forced low while reset is sampled so an aborted instruction leaves no pulse.
    assign bus.iMemRead = rst & imr;
    assign bus.PCSrc    = rst & pcs;
    assign bus.ALUSrc   = rst & als;
    assign bus.RegWrite = rst & rw;
    assign bus.MemtoReg = rst & m2r;
    assign bus.loadPC   = rst & lpc;
    assign bus.ALUCtrl  = rst ? alu : 4'b0000;
    assign bus.MemRead  = rst & mr;
    assign bus.MemWrite = rst & mw;
    assign bus.error    = rst & err;
    assign bus.retired  = rst ? retired_q : 32'd0;
endmodule
